render_food_array: RTL

- Multi-slot food layer for the snake graphics pipeline.
- Holds up to NUM_FOOD food items, each snapped to the CELL grid.
- Accepts spawn requests over a valid/ready handshake and detects eating against the snake head.
- Ages items per frame and retires them on timeout; draws all active items as a registered pixel layer.
- Sits between the LFSR spawn source and the VGA compositor, in parallel with the snake layer.

---
 rtl/render_food_array.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/render_food_array.sv
// Multi-slot food layer: grid-snapped spawn with duplicate rejection, head eat detection,
// per-frame ageing/expiry and a registered sprite layer. Optional blink: RENDER_FOOD_BLINK_EN.
module render_food_array #(
  parameter int          NUM_FOOD        = 4,
  parameter int          CELL            = 16,
  parameter int          SCREEN_W        = 640,
  parameter int          SCREEN_H        = 480,
  parameter int          LIFETIME_FRAMES = 600,
  parameter logic [11:0] FOOD_RGB        = 12'h0F0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_tick,
  input  logic                i_spawn_valid,
  input  logic [9:0]          i_spawn_x,
  input  logic [9:0]          i_spawn_y,
  output logic                o_spawn_ready,
  output logic                o_spawn_dup,
  input  logic                i_eat_check,
  input  logic [9:0]          i_head_x,
  input  logic [9:0]          i_head_y,
  output logic                o_eat,
  output logic [2:0]          o_eat_idx,
  output logic                o_expire,
  output logic [NUM_FOOD-1:0] o_active_mask,
  input  logic [9:0]          i_pixel_x,
  input  logic [9:0]          i_pixel_y,
  input  logic                i_video_on,
  output logic [3:0]          o_vga_r,
  output logic [3:0]          o_vga_g,
  output logic [3:0]          o_vga_b,
  output logic                o_pix_hit
);

  localparam int               AGE_W     = (LIFETIME_FRAMES > 2) ? $clog2(LIFETIME_FRAMES) : 1;
  localparam bit               EXPIRY_EN = (LIFETIME_FRAMES > 0);
  localparam logic [AGE_W-1:0] AGE_LAST  = AGE_W'(EXPIRY_EN ? LIFETIME_FRAMES - 1 : 0);
  localparam logic [9:0]       GRID_MASK = ~10'(CELL - 1);
  localparam logic [9:0]       MAX_X     = 10'(SCREEN_W - CELL);
  localparam logic [9:0]       MAX_Y     = 10'(SCREEN_H - CELL);
  localparam logic [10:0]      CELL_W    = 11'(CELL);

  // Snap to the cell grid, then pull back so the whole sprite stays on screen.
  function automatic logic [9:0] snap(input logic [9:0] v, input logic [9:0] lim);
    logic [9:0] s;
    s = v & GRID_MASK;
    return (s > lim) ? lim : s;
  endfunction

  // Slot table
  logic [NUM_FOOD-1:0] valid_q, valid_d;
  logic [9:0]          x_q   [NUM_FOOD];
  logic [9:0]          x_d   [NUM_FOOD];
  logic [9:0]          y_q   [NUM_FOOD];
  logic [9:0]          y_d   [NUM_FOOD];
  logic [AGE_W-1:0]    age_q [NUM_FOOD];
  logic [AGE_W-1:0]    age_d [NUM_FOOD];

  // Registered outputs
  logic        spawn_ready_q, spawn_ready_d;
  logic        spawn_dup_q,   spawn_dup_d;
  logic        eat_q,         eat_d;
  logic [2:0]  eat_idx_q,     eat_idx_d;
  logic        expire_q,      expire_d;
  logic [11:0] rgb_q,         rgb_d;
  logic        pix_hit_q,     pix_hit_d;

  // Lookup results against the current (pre-update) table
  logic [9:0] spawn_sx, spawn_sy, head_sx, head_sy;
  logic       dup_hit, eat_hit, free_found, accept;
  logic [2:0] eat_k, free_k;
  logic [NUM_FOOD-1:0] visible;

  // Spawn handshake: a request transfers on any edge where i_spawn_valid and
  // o_spawn_ready are both high; the source holds its request until then.
  // Ready reflects the registered table only, so a slot freed this cycle is
  // offered no earlier than the next one.
  assign accept = i_spawn_valid && spawn_ready_q;

  always_comb begin
    spawn_sx   = snap(i_spawn_x, MAX_X);
    spawn_sy   = snap(i_spawn_y, MAX_Y);
    head_sx    = snap(i_head_x, MAX_X);
    head_sy    = snap(i_head_y, MAX_Y);
    dup_hit    = 1'b0;
    eat_hit    = 1'b0;
    eat_k      = 3'd0;
    free_found = 1'b0;
    free_k     = 3'd0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (valid_q[i] && x_q[i] == spawn_sx && y_q[i] == spawn_sy) dup_hit = 1'b1;
      if (valid_q[i] && x_q[i] == head_sx && y_q[i] == head_sy) begin
        eat_hit = 1'b1;
        eat_k   = 3'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_k     = 3'(i);
      end
    end
  end

  // Table next state: ageing/expiry, then eat, then spawn into a free slot.
  always_comb begin
    logic eaten;
    valid_d  = valid_q;
    x_d      = x_q;
    y_d      = y_q;
    age_d    = age_q;
    expire_d = 1'b0;
    for (int i = 0; i < NUM_FOOD; i++) begin
      eaten = i_eat_check && eat_hit && (eat_k == 3'(i));
      if (EXPIRY_EN && valid_q[i] && i_frame_tick) begin
        if (age_q[i] == AGE_LAST) begin
          valid_d[i] = 1'b0;
          if (!eaten) expire_d = 1'b1;
        end else begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
      if (eaten) valid_d[i] = 1'b0;
      if (accept && !dup_hit && free_found && (free_k == 3'(i))) begin
        valid_d[i] = 1'b1;
        x_d[i]     = spawn_sx;
        y_d[i]     = spawn_sy;
        age_d[i]   = '0;
      end
    end
  end

  always_comb begin
    spawn_ready_d = ~&valid_d;
    spawn_dup_d   = accept && dup_hit;
    eat_d         = i_eat_check && eat_hit;
    eat_idx_d     = eat_d ? eat_k : 3'd0;
  end

`ifdef RENDER_FOOD_BLINK_EN
  logic [2:0] blink_cnt_q, blink_cnt_d;

  assign blink_cnt_d = i_frame_tick ? blink_cnt_q + 3'd1 : blink_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) blink_cnt_q <= 3'd0;
    else          blink_cnt_q <= blink_cnt_d;
  end

  // Items within 64 frames of expiry flash 4 frames on, 4 frames off.
  always_comb begin
    visible = '1;
    for (int i = 0; i < NUM_FOOD; i++) begin
      if (EXPIRY_EN && (LIFETIME_FRAMES - int'(age_q[i]) <= 64) && blink_cnt_q[2])
        visible[i] = 1'b0;
    end
  end
`else
  assign visible = '1;
`endif

  // Render: 11-bit bounds so x+CELL near the right/bottom edge cannot wrap.
  always_comb begin
    pix_hit_d = 1'b0;
    for (int i = 0; i < NUM_FOOD; i++) begin
      if (valid_q[i] && visible[i] &&
          ({1'b0, i_pixel_x} >= {1'b0, x_q[i]}) &&
          ({1'b0, i_pixel_x} <  {1'b0, x_q[i]} + CELL_W) &&
          ({1'b0, i_pixel_y} >= {1'b0, y_q[i]}) &&
          ({1'b0, i_pixel_y} <  {1'b0, y_q[i]} + CELL_W))
        pix_hit_d = 1'b1;
    end
    pix_hit_d = pix_hit_d && i_video_on;
    rgb_d     = pix_hit_d ? FOOD_RGB : 12'h000;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q       <= '0;
      spawn_ready_q <= 1'b0;
      spawn_dup_q   <= 1'b0;
      eat_q         <= 1'b0;
      eat_idx_q     <= 3'd0;
      expire_q      <= 1'b0;
      rgb_q         <= 12'h000;
      pix_hit_q     <= 1'b0;
      for (int i = 0; i < NUM_FOOD; i++) begin
        x_q[i]   <= 10'd0;
        y_q[i]   <= 10'd0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      spawn_ready_q <= spawn_ready_d;
      spawn_dup_q   <= spawn_dup_d;
      eat_q         <= eat_d;
      eat_idx_q     <= eat_idx_d;
      expire_q      <= expire_d;
      rgb_q         <= rgb_d;
      pix_hit_q     <= pix_hit_d;
      for (int i = 0; i < NUM_FOOD; i++) begin
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  assign o_spawn_ready = spawn_ready_q;
  assign o_spawn_dup   = spawn_dup_q;
  assign o_eat         = eat_q;
  assign o_eat_idx     = eat_idx_q;
  assign o_expire      = expire_q;
  assign o_active_mask = valid_q;
  assign o_vga_r       = rgb_q[11:8];
  assign o_vga_g       = rgb_q[7:4];
  assign o_vga_b       = rgb_q[3:0];
  assign o_pix_hit     = pix_hit_q;

endmodule
